// File: rtl/board_io_pkg.sv
// Shared board I/O definitions: button FSM states and default board timing.
// Used by the button conditioning front end and its sibling switch/button stages.
package board_io_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } btn_state_t;

  localparam int CLK_HZ      = 100_000_000;
  localparam int DEBOUNCE_MS = 10;

  // 10 ms of stability at the board clock.
  localparam int DEFAULT_DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;

endpackage

// File: rtl/sync_chain.sv
// Parameterised flop synchroniser for asynchronous pad inputs (buttons, switches).
// dout is the last stage; nothing downstream should look at din directly.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] stage_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stage_reg[0] <= 1'b0;
    else       stage_reg[0] <= din;
  end

  genvar gi;
  generate
    for (gi = 1; gi < STAGES; gi++) begin : g_stage
      always_ff @(posedge clk or posedge reset) begin
        if (reset) stage_reg[gi] <= 1'b0;
        else       stage_reg[gi] <= stage_reg[gi-1];
      end
    end
  endgenerate

  assign dout = stage_reg[STAGES-1];

endmodule

// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: synchronise, debounce with a stability counter, emit level
// plus one-cycle press/release pulses. Define BTN_AUTOREPEAT_EN for held-button repeats.
module btn_debounce_pulse
  import board_io_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_RATE     = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_pressed,
  output logic btn_released
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  generate
    if (DEBOUNCE_CYCLES < 2 || SYNC_STAGES < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
      $error("btn_debounce_pulse: illegal parameter value");
    end
  endgenerate

  logic sync_in;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (btn_raw),
    .dout  (sync_in)
  );

  btn_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             level_reg, level_next;
  logic             pressed_reg, pressed_next;
  logic             released_reg, released_next;
  logic             repeat_fire;

`ifdef BTN_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
  localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_AGAIN = RPT_W'(REPEAT_DELAY + REPEAT_RATE - 1);
  localparam logic [RPT_W-1:0] RPT_BASE  = RPT_W'(REPEAT_DELAY);

  logic [RPT_W-1:0] rpt_reg, rpt_next;

  // Counter only runs while PRESSED is held; a due repeat is dropped if sync_in has fallen.
  always_comb begin
    rpt_next    = '0;
    repeat_fire = 1'b0;
    if (state_reg == PRESSED && sync_in) begin
      if (rpt_reg == RPT_FIRST || rpt_reg == RPT_AGAIN) begin
        repeat_fire = 1'b1;
        rpt_next    = RPT_BASE;
      end else begin
        rpt_next = rpt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rpt_reg <= '0;
    else       rpt_reg <= rpt_next;
  end
`else
  assign repeat_fire = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (sync_in) begin
          state_next = WAIT_PRESS;
          cnt_next   = '0;
        end
      end
      WAIT_PRESS: begin
        if (!sync_in)                state_next = IDLE;
        else if (cnt_reg == CNT_LAST) state_next = PRESSED;
        else                         cnt_next   = cnt_reg + 1'b1;
      end
      PRESSED: begin
        if (!sync_in) begin
          state_next = WAIT_RELEASE;
          cnt_next   = '0;
        end
      end
      WAIT_RELEASE: begin
        if (sync_in)                 state_next = PRESSED;
        else if (cnt_reg == CNT_LAST) state_next = IDLE;
        else                         cnt_next   = cnt_reg + 1'b1;
      end
      default: state_next = IDLE;
    endcase

    level_next    = (state_next == PRESSED) || (state_next == WAIT_RELEASE);
    pressed_next  = ((state_reg == WAIT_PRESS) && (state_next == PRESSED)) || repeat_fire;
    released_next = (state_reg == WAIT_RELEASE) && (state_next == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      level_reg    <= 1'b0;
      pressed_reg  <= 1'b0;
      released_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      level_reg    <= level_next;
      pressed_reg  <= pressed_next;
      released_reg <= released_next;
    end
  end

  assign btn_level    = level_reg;
  assign btn_pressed  = pressed_reg;
  assign btn_released = released_reg;

endmodule
